mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_if.sv | 37 +++
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle between the two core requesters, the arbiter and the unified memory port.
// The arbiter connects through the slave modport; the core/memory side uses master.
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ack;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_ack;
   logic              bus_err;
   logic              stall;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
      output if_rdata, if_ack, d_rdata, d_ack, bus_err, stall,
             mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
      input  if_rdata, if_ack, d_rdata, d_ack, bus_err, stall,
             mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises instruction-fetch and load/store traffic onto one memory port with
// alternating priority on conflict and a response watchdog.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input logic                clk,
   input logic                reset,
   mem_port_arbiter_if.slave  bus
);

   localparam int unsigned     CntW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};
   localparam logic            GntData = 1'b1;

   typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

   state_e            state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              if_ack_q, if_ack_d;
   logic              d_ack_q, d_ack_d;
   logic              bus_err_q, bus_err_d;
   logic              gnt;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      if_rdata_d   = if_rdata_q;
      d_rdata_d    = d_rdata_q;
      if_ack_d     = if_ack_q;
      d_ack_d      = d_ack_q;
      bus_err_d    = bus_err_q;
      // On conflict the requester that did not win last time gets the port.
      gnt = (bus.if_req & bus.d_req) ? ~last_grant_q : bus.d_req;

      unique case (state_q)
         StIdle: begin
            if (bus.if_req | bus.d_req) begin
               state_d      = StBusy;
               last_grant_d = gnt;
               cnt_d        = '0;
               mem_req_d    = 1'b1;
               if (gnt == GntData) begin
                  mem_we_d    = bus.d_we;
                  mem_addr_d  = {bus.d_addr[ADDR_W-1:2], 2'b00};
                  mem_wdata_d = bus.d_wdata;
               end else begin
                  mem_we_d    = 1'b0;
                  mem_addr_d  = {bus.if_addr[ADDR_W-1:2], 2'b00};
                  mem_wdata_d = '0;
               end
            end
         end
         StBusy: begin
            if (bus.mem_ack) begin
               state_d   = StResp;
               mem_req_d = 1'b0;
               if_ack_d  = (last_grant_q != GntData);
               d_ack_d   = (last_grant_q == GntData);
               if (last_grant_q != GntData) begin
                  if_rdata_d = bus.mem_rdata;
               end else if (!mem_we_q) begin
                  d_rdata_d = bus.mem_rdata;
               end
            end else if ((TIMEOUT != 0) && (cnt_q == CntLast)) begin
               state_d   = StResp;
               mem_req_d = 1'b0;
               bus_err_d = 1'b1;
               if_ack_d  = (last_grant_q != GntData);
               d_ack_d   = (last_grant_q == GntData);
               if (last_grant_q != GntData) begin
                  if_rdata_d = '0;
               end else begin
                  d_rdata_d = '0;
               end
            end else if (cnt_q != CntMax) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StResp: begin
            state_d   = StIdle;
            if_ack_d  = 1'b0;
            d_ack_d   = 1'b0;
            bus_err_d = 1'b0;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         last_grant_q <= GntData;
         cnt_q        <= '0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         if_rdata_q   <= '0;
         d_rdata_q    <= '0;
         if_ack_q     <= 1'b0;
         d_ack_q      <= 1'b0;
         bus_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         if_rdata_q   <= if_rdata_d;
         d_rdata_q    <= d_rdata_d;
         if_ack_q     <= if_ack_d;
         d_ack_q      <= d_ack_d;
         bus_err_q    <= bus_err_d;
      end
   end

   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.if_ack    = if_ack_q;
   assign bus.d_ack     = d_ack_q;
   assign bus.bus_err   = bus_err_q;
   assign bus.stall     = (bus.if_req & ~if_ack_q) | (bus.d_req & ~d_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: requesters push expected responses into
// per-port queues and a monitor pops and compares them on every acknowledge.
module tb_mem_port_arbiter;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic clk;
   logic reset;
   int   n_chk  = 0;
   int   n_fail = 0;
   int   ack_delay;
   bit   inject_ack;
   exp_t q_if[$];
   exp_t q_d[$];
   bit   ack_log[$];
   logic [31:0] mem_model [0:255];

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Waits (bounded) for the selected ack; reports cycles waited and the first mem_* beat.
   task automatic wait_ack(input bit is_d, input bit chk_stall, output int cyc, output int nreq,
                           output logic [31:0] a, output logic we, output logic [31:0] wd);
      bit got = 0;
      cyc = 0; nreq = 0; a = 'x; we = 'x; wd = 'x;
      while (!got && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (bus.mem_req) begin
            if (nreq == 0) begin
               a = bus.mem_addr; we = bus.mem_we; wd = bus.mem_wdata;
            end
            nreq++;
         end
         if (is_d ? bus.d_ack : bus.if_ack) begin
            got = 1;
            if (chk_stall) chk("stall_in_ack_cycle", {31'b0, bus.stall}, 0);
         end else if (chk_stall) begin
            chk("stall_while_waiting", {31'b0, bus.stall}, 1);
         end
      end
      if (!got) chk("ack_wait_expired", 0, 1);
   endtask

   // Memory model: acks in BUSY cycle ack_delay (never if negative); writes update the model.
   initial begin : responder
      int busy;
      for (int i = 0; i < 256; i++) mem_model[i] = 32'h0;
      mem_model[8'h41] = 32'h0050_0093;
      mem_model[8'h10] = 32'h0BAD_0BAD;
      mem_model[8'h80] = 32'h1111_0001;
      mem_model[8'h81] = 32'h1111_0002;
      mem_model[8'hC0] = 32'h2222_0003;
      mem_model[8'hC1] = 32'h2222_0004;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 32'h0;
      busy = 0;
      forever begin
         @(negedge clk);
         if (bus.mem_req && !reset) begin
            if (ack_delay >= 0 && busy == ack_delay) begin
               bus.mem_ack   = 1'b1;
               bus.mem_rdata = mem_model[bus.mem_addr[9:2]];
               if (bus.mem_we) mem_model[bus.mem_addr[9:2]] = bus.mem_wdata;
            end else begin
               bus.mem_ack   = 1'b0;
               bus.mem_rdata = 32'hA5A5_A5A5;
            end
            busy++;
         end else begin
            busy          = 0;
            bus.mem_ack   = inject_ack;
            bus.mem_rdata = 32'h5A5A_5A5A;
         end
      end
   end

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            chk("acks_exclusive", {31'b0, bus.if_ack & bus.d_ack}, 0);
            chk("err_only_with_ack", {31'b0, bus.bus_err & ~(bus.if_ack | bus.d_ack)}, 0);
            if (bus.if_ack) begin
               ack_log.push_back(1'b0);
               chk("if_ack_expected", {31'b0, q_if.size() != 0}, 1);
               if (q_if.size() != 0) begin
                  e = q_if.pop_front();
                  chk("if_rdata", bus.if_rdata, e.rdata);
                  chk("if_bus_err", {31'b0, bus.bus_err}, {31'b0, e.err});
               end
            end
            if (bus.d_ack) begin
               ack_log.push_back(1'b1);
               chk("d_ack_expected", {31'b0, q_d.size() != 0}, 1);
               if (q_d.size() != 0) begin
                  e = q_d.pop_front();
                  chk("d_rdata", bus.d_rdata, e.rdata);
                  chk("d_bus_err", {31'b0, bus.bus_err}, {31'b0, e.err});
               end
            end
         end
      end
   end

   initial begin : global_watchdog
      #100000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "bench time limit");
   end

   initial begin : stimulus
      int cyc, nreq, c1, n1, c2, n2, base;
      logic [31:0] a, wd, a1, wd1, a2, wd2;
      logic we, we1, we2;

      reset = 1'b1; ack_delay = 0; inject_ack = 1'b0;
      bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0;
      bus.d_addr = 0; bus.d_wdata = 0;
      repeat (2) @(negedge clk);
      chk("rst_mem_req", {31'b0, bus.mem_req}, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_if_ack", {31'b0, bus.if_ack}, 0);
      chk("rst_d_ack", {31'b0, bus.d_ack}, 0);
      chk("rst_stall", {31'b0, bus.stall}, 0);
      reset = 1'b0;

      // Fetch only; d_wdata junk must not leak into the fetch beat.
      bus.d_wdata = 32'hFFFF_FFFF;
      bus.if_addr = 32'h0000_0106; bus.if_req = 1;
      q_if.push_back('{rdata: 32'h0050_0093, err: 1'b0});
      wait_ack(0, 0, cyc, nreq, a, we, wd);
      bus.if_req = 0; bus.d_wdata = 0;
      chk("fetch_latency", cyc, 2);
      chk("fetch_mem_req_cycles", nreq, 1);
      chk("fetch_mem_addr", a, 32'h0000_0104);
      chk("fetch_mem_we", {31'b0, we}, 0);
      chk("fetch_mem_wdata", wd, 0);

      // Store to 0x40; d_rdata must keep its reset value.
      bus.d_we = 1; bus.d_addr = 32'h40; bus.d_wdata = 32'hDEAD_BEEF; bus.d_req = 1;
      q_d.push_back('{rdata: 32'h0, err: 1'b0});
      wait_ack(1, 0, cyc, nreq, a, we, wd);
      bus.d_req = 0;
      chk("store_mem_addr", a, 32'h40);
      chk("store_mem_we", {31'b0, we}, 1);
      chk("store_mem_wdata", wd, 32'hDEAD_BEEF);
      chk("store_mem_req_cycles", nreq, 1);

      // Load back from 0x40.
      @(negedge clk);
      bus.d_we = 0; bus.d_wdata = 32'h1234_5678; bus.d_req = 1;
      q_d.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b0});
      wait_ack(1, 0, cyc, nreq, a, we, wd);
      bus.d_req = 0;
      chk("load_mem_we", {31'b0, we}, 0);
      chk("load_latency", cyc, 2);

      // Watchdog: load that memory never answers.
      ack_delay = -1;
      @(negedge clk);
      bus.d_addr = 32'h84; bus.d_req = 1;
      q_d.push_back('{rdata: 32'h0, err: 1'b1});
      wait_ack(1, 0, cyc, nreq, a, we, wd);
      bus.d_req = 0;
      chk("timeout_mem_req_cycles", nreq, 16);
      chk("timeout_ack_cycle", cyc, 17);
      ack_delay = 0;
      @(negedge clk);
      chk("timeout_back_idle_no_req", {31'b0, bus.mem_req}, 0);

      // Late ack in the 5th BUSY cycle with stall tracking; stray mem_ack outside BUSY.
      ack_delay = 4; inject_ack = 1;
      @(negedge clk);
      bus.if_addr = 32'h200; bus.if_req = 1;
      q_if.push_back('{rdata: 32'h1111_0001, err: 1'b0});
      #1 chk("stall_at_request", {31'b0, bus.stall}, 1);
      wait_ack(0, 1, cyc, nreq, a, we, wd);
      bus.if_req = 0;
      chk("late_ack_latency", cyc, 6);
      chk("late_ack_mem_req_cycles", nreq, 5);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stray_mem_ack_no_req", {31'b0, bus.mem_req}, 0);
      end
      inject_ack = 0; ack_delay = 0;

      // Conflict from reset: both held for two transactions each.
      reset = 1;
      @(negedge clk);
      bus.if_addr = 32'h200; bus.if_req = 1;
      bus.d_we = 0; bus.d_addr = 32'h300; bus.d_req = 1;
      q_if.push_back('{rdata: 32'h1111_0001, err: 1'b0});
      q_d.push_back('{rdata: 32'h2222_0003, err: 1'b0});
      base = ack_log.size();
      @(negedge clk);
      reset = 0;
      fork
         begin
            wait_ack(0, 0, c1, n1, a1, we1, wd1);
            bus.if_addr = 32'h204;
            q_if.push_back('{rdata: 32'h1111_0002, err: 1'b0});
            wait_ack(0, 0, c1, n1, a1, we1, wd1);
            bus.if_req = 0;
         end
         begin
            wait_ack(1, 0, c2, n2, a2, we2, wd2);
            bus.d_addr = 32'h304;
            q_d.push_back('{rdata: 32'h2222_0004, err: 1'b0});
            wait_ack(1, 0, c2, n2, a2, we2, wd2);
            bus.d_req = 0;
         end
      join
      chk("conflict_ack_count", ack_log.size() - base, 4);
      chk("conflict_order_0", {31'b0, ack_log[base]}, 0);
      chk("conflict_order_1", {31'b0, ack_log[base+1]}, 1);
      chk("conflict_order_2", {31'b0, ack_log[base+2]}, 0);
      chk("conflict_order_3", {31'b0, ack_log[base+3]}, 1);

      // Reset in BUSY: outputs clear without a clock edge; fetch wins after release.
      ack_delay = -1;
      @(negedge clk);
      bus.if_addr = 32'h104; bus.if_req = 1;
      repeat (3) @(negedge clk);
      chk("busy_before_reset", {31'b0, bus.mem_req}, 1);
      #2 reset = 1;
      #1;
      chk("async_rst_mem_req", {31'b0, bus.mem_req}, 0);
      chk("async_rst_if_ack", {31'b0, bus.if_ack}, 0);
      chk("async_rst_d_ack", {31'b0, bus.d_ack}, 0);
      chk("async_rst_if_rdata", bus.if_rdata, 0);
      chk("async_rst_d_rdata", bus.d_rdata, 0);
      chk("async_rst_mem_addr", bus.mem_addr, 0);
      q_if.delete();
      bus.if_addr = 32'h200; bus.d_addr = 32'h300; bus.d_we = 0; bus.d_req = 1;
      q_if.push_back('{rdata: 32'h1111_0001, err: 1'b0});
      q_d.push_back('{rdata: 32'h2222_0003, err: 1'b0});
      ack_delay = 0;
      base = ack_log.size();
      @(negedge clk);
      reset = 0;
      fork
         begin
            wait_ack(0, 0, c1, n1, a1, we1, wd1);
            bus.if_req = 0;
         end
         begin
            wait_ack(1, 0, c2, n2, a2, we2, wd2);
            bus.d_req = 0;
         end
      join
      chk("post_reset_ack_count", ack_log.size() - base, 2);
      chk("post_reset_fetch_first", {31'b0, ack_log[base]}, 0);
      chk("post_reset_data_second", {31'b0, ack_log[base+1]}, 1);

      repeat (3) @(negedge clk);
      chk("if_queue_drained", q_if.size(), 0);
      chk("d_queue_drained", q_d.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
